// File: rtl/sm83_pkg.sv
// Shared types for the SM83 memory subsystem: bus widths, access ownership
// and the arbiter's single-entry access stage.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_t;

    typedef enum logic [1:0] {
        IDLE,
        CPU_ACC,
        DMA_ACC
    } arb_state_t;

    typedef struct packed {
        logic  we;
        addr_t addr;
        data_t wdata;
    } stage_t;

    // The FSM state names exactly who owns the stage register.
    function automatic owner_t state_owner(arb_state_t s);
        case (s)
            CPU_ACC: return OWN_CPU;
            DMA_ACC: return OWN_DMA;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter onto a single-port memory with combinational read
// data. DMA wins by default, but the CPU is forced in after DMA_BURST DMA grants.
module mem_arbiter
    import sm83_pkg::*;
#(
    parameter int unsigned DMA_BURST = 4
) (
    input  logic  clk,
    input  logic  rst_n,

    input  logic  cpu_req,
    input  logic  cpu_we,
    input  addr_t cpu_addr,
    input  data_t cpu_wdata,
    output logic  cpu_gnt,
    output logic  cpu_rvalid,
    output data_t cpu_rdata,

    input  logic  dma_req,
    input  logic  dma_we,
    input  addr_t dma_addr,
    input  data_t dma_wdata,
    output logic  dma_gnt,
    output logic  dma_rvalid,
    output data_t dma_rdata,

    output logic  mem_wen,
    output addr_t mem_w_addr,
    output addr_t mem_r_addr,
    output data_t mem_w_data,
    input  data_t mem_r_data
);

    localparam int CNT_W = $clog2(DMA_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(DMA_BURST);

    arb_state_t       state;
    stage_t           stage;
    logic [CNT_W-1:0] burst_cnt;
    owner_t           owner;
    logic             cpu_turn;

    // A waiting CPU that has watched DMA_BURST DMA grants go by takes this slot.
    assign cpu_turn = cpu_req && (burst_cnt == BURST_MAX);
    assign dma_gnt  = rst_n && dma_req && !cpu_turn;
    assign cpu_gnt  = rst_n && cpu_req && !dma_gnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage     <= '0;
            burst_cnt <= '0;
        end else begin
            if (cpu_gnt) begin
                state <= CPU_ACC;
                stage <= '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
            end else if (dma_gnt) begin
                state <= DMA_ACC;
                stage <= '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
            end else begin
                // Stage contents are kept so the address outputs hold while idle.
                state <= IDLE;
            end

            if (!cpu_req || cpu_gnt) begin
                burst_cnt <= '0;
            end else if (dma_gnt && burst_cnt != BURST_MAX) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

    assign owner      = state_owner(state);

    assign mem_wen    = (owner != OWN_NONE) && stage.we;
    assign mem_w_addr = stage.addr;
    assign mem_r_addr = stage.addr;
    assign mem_w_data = stage.wdata;

    assign cpu_rvalid = (owner == OWN_CPU) && !stage.we;
    assign dma_rvalid = (owner == OWN_DMA) && !stage.we;
    assign cpu_rdata  = cpu_rvalid ? mem_r_data : '0;
    assign dma_rdata  = dma_rvalid ? mem_r_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed sequences, a grant table and randomized
// traffic against a transaction-level model with its own memory image.
module tb_mem_arbiter;
    import sm83_pkg::*;

    localparam int unsigned DMA_BURST = 4;
    localparam int          N_RND     = 3000;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    addr_t cpu_addr;
    data_t cpu_wdata, cpu_rdata;
    logic  dma_req, dma_we, dma_gnt, dma_rvalid;
    addr_t dma_addr;
    data_t dma_wdata, dma_rdata;
    logic  mem_wen;
    addr_t mem_w_addr, mem_r_addr;
    data_t mem_w_data, mem_r_data;

    always #5 clk = ~clk;

    mem_arbiter #(.DMA_BURST(DMA_BURST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_wen    (mem_wen),
        .mem_w_addr (mem_w_addr),
        .mem_r_addr (mem_r_addr),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    function automatic data_t preload_val(int a);
        case (a)
            0:       return 8'h3E;
            1:       return 8'hBE;
            2:       return 8'h3C;
            default: return 8'(a * 7 + 1);
        endcase
    endfunction

    // Memory model: loaded on the first edge, then written only by the DUT.
    data_t mem [0:65535];
    bit    loaded = 1'b0;
    assign mem_r_data = mem[mem_r_addr];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int a = 0; a < 512; a++) mem[a] <= preload_val(a);
            loaded <= 1'b1;
        end else if (mem_wen) begin
            mem[mem_w_addr] <= mem_w_data;
        end
    end

    bit watch = 1'b0;
    bit wen_seen = 1'b0;
    always @(mem_wen) if (watch && mem_wen) wen_seen = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_quiet(input string name);
        check({name, "_ctl"},  {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_wen}, '0);
        check({name, "_data"}, {cpu_rdata, dma_rdata, mem_w_data}, '0);
        check({name, "_addr"}, {mem_w_addr, mem_r_addr}, '0);
    endtask

    task automatic drive(input logic c_req, input logic c_we, input addr_t c_addr, input data_t c_wd,
                         input logic d_req, input logic d_we, input addr_t d_addr, input data_t d_wd);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic cpu_req;
        logic dma_req;
        logic exp_cpu;
        logic exp_dma;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, input logic d, input logic ec, input logic ed);
        vec_t v;
        v.cpu_req = c; v.dma_req = d; v.exp_cpu = ec; v.exp_dma = ed;
        tbl.push_back(v);
    endtask

    typedef struct {
        int         owner;
        logic       we;
        logic [3:0] idx;
        data_t      wd;
    } acc_t;

    initial begin
        logic  pc, pd;
        data_t ref_mem [16];
        acc_t  prev, cur;
        int    streak, cpu_wait, grants, accesses;
        logic  c_req, c_we, d_req, d_we, exp_c, exp_d, exp_wen;
        addr_t c_addr, d_addr;
        data_t c_wd, d_wd, exp_cd, exp_dd;

        // Reset with both requests asserted: nothing may be granted.
        rst_n = 1'b0;
        drive(1, 0, 16'h0000, '0, 1, 0, 16'h0001, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset_hold");
        idle();
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check_quiet("post_reset");
        next_cycle();

        // CPU read of preloaded location 0.
        drive(1, 0, 16'h0000, '0, 0, 0, '0, '0);
        @(negedge clk);
        check("cpu_rd_gnt", {cpu_gnt, dma_gnt}, 2'b10);
        next_cycle();
        idle();
        @(negedge clk);
        check("cpu_rd_rsp", {cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata}, {2'b10, 8'h3E, 8'h00});
        next_cycle();

        // Write then read the same address on consecutive cycles.
        drive(1, 1, 16'h0010, 8'h55, 0, 0, '0, '0);
        @(negedge clk);
        check("cpu_wr_gnt", cpu_gnt, 1'b1);
        next_cycle();
        drive(1, 0, 16'h0010, '0, 0, 0, '0, '0);
        @(negedge clk);
        check("cpu_rd2_gnt", cpu_gnt, 1'b1);
        check("cpu_wr_port", {mem_wen, mem_w_addr, mem_w_data, cpu_rvalid}, {1'b1, 16'h0010, 8'h55, 1'b0});
        next_cycle();
        idle();
        @(negedge clk);
        check("cpu_raw_rsp", {cpu_rvalid, cpu_rdata, mem_wen}, {1'b1, 8'h55, 1'b0});
        next_cycle();

        // DMA back-to-back reads of 0..2.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(0, 0, '0, '0, 1, 0, addr_t'(i), '0);
            else       idle();
            @(negedge clk);
            if (i < 3) check("dma_b2b_gnt", {cpu_gnt, dma_gnt}, 2'b01);
            if (i > 0) check("dma_b2b_rsp", {cpu_rvalid, dma_rvalid, dma_rdata}, {2'b01, preload_val(i - 1)});
            next_cycle();
        end
        @(negedge clk);
        check("dma_b2b_end", {cpu_rvalid, dma_rvalid}, 2'b00);

        // Grant table: burst rotation, idle and single-requester cases.
        add(0, 0, 0, 0);
        add(1, 0, 1, 0);
        add(0, 1, 0, 1);
        for (int r = 0; r < 2; r++) begin
            add(1, 1, 0, 1); add(1, 1, 0, 1); add(1, 1, 0, 1); add(1, 1, 0, 1);
            add(1, 1, 1, 0);
        end
        add(1, 1, 0, 1); add(1, 1, 0, 1);
        add(0, 1, 0, 1);
        add(1, 1, 0, 1); add(1, 1, 0, 1); add(1, 1, 0, 1); add(1, 1, 0, 1);
        add(1, 1, 1, 0);
        add(1, 0, 1, 0);

        pc = 1'b0; pd = 1'b0;
        next_cycle();
        foreach (tbl[i]) begin
            drive(tbl[i].cpu_req, 0, 16'h0020, '0, tbl[i].dma_req, 0, 16'h0040, '0);
            @(negedge clk);
            check("tbl_gnt", {cpu_gnt, dma_gnt}, {tbl[i].exp_cpu, tbl[i].exp_dma});
            check("tbl_rvalid", {cpu_rvalid, dma_rvalid}, {pc, pd});
            pc = tbl[i].exp_cpu; pd = tbl[i].exp_dma;
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("tbl_rvalid_last", {cpu_rvalid, dma_rvalid}, {pc, pd});
        next_cycle();

        // DMA write granted, then reset lands before the capture edge.
        drive(0, 0, '0, '0, 1, 1, 16'h0001, 8'h77);
        watch = 1'b1;
        @(negedge clk);
        check("abort_gnt", dma_gnt, 1'b1);
        #1;
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_quiet("abort_in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        watch = 1'b0;
        check("abort_no_wen", wen_seen, 1'b0);
        check("abort_mem", mem[1], 8'hBE);
        check_quiet("abort_after");
        next_cycle();

        // Randomized traffic against the transaction-level model.
        for (int a = 0; a < 16; a++) ref_mem[a] = preload_val(256 + a);
        prev = '{owner: 0, we: 1'b0, idx: 4'h0, wd: 8'h00};
        streak = 0; cpu_wait = 0; grants = 0; accesses = 0;
        c_req = 0; c_we = 0; c_addr = '0; c_wd = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wd = '0;
        for (int i = 0; i < N_RND + 2; i++) begin
            if (i >= N_RND) begin
                c_req = 0; d_req = 0;
            end else begin
                if (!c_req && $urandom_range(0, 2) != 0) begin
                    c_req = 1; c_we = 1'($urandom_range(0, 1));
                    c_addr = 16'h0100 | 16'($urandom_range(0, 15)); c_wd = 8'($urandom);
                end
                if (d_req && $urandom_range(0, 7) == 0) begin
                    d_req = 0;
                end else if (!d_req && $urandom_range(0, 3) != 0) begin
                    d_req = 1; d_we = 1'($urandom_range(0, 1));
                    d_addr = 16'h0100 | 16'($urandom_range(0, 15)); d_wd = 8'($urandom);
                end
            end
            drive(c_req, c_we, c_addr, c_wd, d_req, d_we, d_addr, d_wd);
            @(negedge clk);

            exp_d = d_req && !(c_req && streak == int'(DMA_BURST));
            exp_c = c_req && !exp_d;
            check("rnd_gnt", {cpu_gnt, dma_gnt}, {exp_c, exp_d});

            exp_cd  = (prev.owner == 1 && !prev.we) ? ref_mem[prev.idx] : 8'h00;
            exp_dd  = (prev.owner == 2 && !prev.we) ? ref_mem[prev.idx] : 8'h00;
            exp_wen = (prev.owner != 0) && prev.we;
            check("rnd_rsp", {cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata},
                  {prev.owner == 1 && !prev.we, prev.owner == 2 && !prev.we, exp_cd, exp_dd});
            check("rnd_wen", mem_wen, exp_wen);
            if (exp_wen)
                check("rnd_wport", {mem_w_addr, mem_w_data}, {12'h010, prev.idx, prev.wd});

            grants   += int'(cpu_gnt) + int'(dma_gnt);
            accesses += int'(cpu_rvalid || dma_rvalid) + int'(mem_wen);

            if (exp_c) begin
                check("rnd_cpu_wait", (cpu_wait + 1) <= int'(DMA_BURST) + 1, 1'b1);
                cpu_wait = 0;
            end else if (c_req) begin
                cpu_wait++;
            end

            if (exp_wen) ref_mem[prev.idx] = prev.wd;
            if (!c_req || exp_c)                              streak = 0;
            else if (exp_d && streak < int'(DMA_BURST))        streak++;

            cur = '{owner: 0, we: 1'b0, idx: 4'h0, wd: 8'h00};
            if (exp_c) cur = '{owner: 1, we: c_we, idx: c_addr[3:0], wd: c_wd};
            if (exp_d) cur = '{owner: 2, we: d_we, idx: d_addr[3:0], wd: d_wd};
            prev = cur;

            next_cycle();
            if (exp_c) c_req = 0;
            if (exp_d) d_req = 0;
        end
        check("rnd_access_count", accesses, grants);
        for (int a = 0; a < 16; a++) check("rnd_mem", mem[256 + a], ref_mem[a]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DMA_BURST, default 4: max consecutive DMA grants while cpu_req is pending.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cpu_req, cpu_we  in  1  CPU access request; 1 = write.
REQ-005 cpu_addr  in  addr_t; cpu_wdata  in  data_t  CPU address / write data.
REQ-006 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-007 cpu_rvalid  out  1; cpu_rdata  out  data_t  CPU read response.
REQ-008 dma_req, dma_we  in  1; dma_addr  in  addr_t; dma_wdata  in  data_t  DMA request port.
REQ-009 dma_gnt, dma_rvalid  out  1; dma_rdata  out  data_t  DMA grant/response.
REQ-010 mem_wen  out  1; mem_w_addr, mem_r_addr  out  addr_t; mem_w_data  out  data_t  memory port.
REQ-011 mem_r_data  in  data_t  combinational read data for mem_r_addr.

Function
REQ-012 Grant is combinational from req inputs and state; at most one of cpu_gnt/dma_gnt high per cycle.
REQ-013 Request held high with stable addr/we/wdata until granted; drop without grant is legal.
REQ-014 Granted request captured into one stage register (owner, we, addr, wdata) at the grant edge.
REQ-015 FSM states IDLE, CPU_ACC, DMA_ACC = owner of stage register; next state from grant, IDLE if none.
REQ-016 In CPU_ACC/DMA_ACC, mem_r_addr = mem_w_addr = stage addr; mem_wen = stage we; mem_w_data = stage wdata.
REQ-017 In IDLE, mem_wen = 0; address outputs hold last value.
REQ-018 Read latency 1: rvalid of owner high in the cycle after grant, rdata = mem_r_data that cycle.
REQ-019 Write: no rvalid; memory updates at end of the cycle after grant.
REQ-020 Non-owner rdata = 0; rvalid is high only in owner state with stage we = 0.
REQ-021 Back-to-back grants allowed every cycle (throughput 1 access/cycle).
REQ-022 Priority: DMA over CPU, unless burst counter = DMA_BURST with cpu_req high -> CPU granted.
REQ-023 Burst counter: +1 per DMA grant while cpu_req high; cleared on CPU grant or cpu_req low; saturates at DMA_BURST.
REQ-024 Only one requester active -> granted every cycle it requests.
REQ-025 Read of stage address following a write to it sees written data (memory is write-then-read ordered by edges; no forwarding needed).
REQ-026 Simultaneous requests to same address: order per REQ-022; each sees prior access's effect.

Reset
REQ-027 rst_n low: state IDLE, burst counter 0, stage cleared (we 0, addr 0, wdata 0).
REQ-028 During and after reset until first grant: gnt 0, rvalid 0, rdata 0, mem_wen 0, addresses 0.
REQ-029 Reset mid-access: in-flight access aborted, no write issued, no rvalid.

Structure
REQ-030 addr_t, data_t from sm83_pkg; owner enum (OWN_NONE, OWN_CPU, OWN_DMA) added to sm83_pkg.
REQ-031 Single flat module; no sub-module.

Verification
REQ-032 Reset, memory preloaded 0x3E,0xBE,0x3C; CPU read 0x0000 -> cpu_gnt same cycle, cpu_rvalid next cycle, cpu_rdata 0x3E.
REQ-033 CPU write 0x55 to 0x0010, then read 0x0010 next cycle -> cpu_rdata 0x55 one cycle after read grant.
REQ-034 cpu_req and dma_req held continuously, DMA_BURST 4 -> grant pattern D,D,D,D,C repeating.
REQ-035 DMA reads 0x0000..0x0002 back-to-back -> dma_rvalid 3 consecutive cycles, data 0x3E,0xBE,0x3C; cpu_rvalid 0.
REQ-036 DMA write granted, rst_n low before next edge -> mem_wen never high, target location unchanged.
REQ-037 Random req traffic: gnt one-hot-or-zero every cycle; every grant yields exactly one access; no CPU wait > DMA_BURST+1 cycles.
